// File: rtl/decode_ctrl_pipe.sv
// RV32 decode stage: turns R/I-ALU/load/store instruction words into ALU control
// signals, flags and counts illegal encodings, and buffers results in a 2-entry FIFO.
module decode_ctrl_pipe #(
  parameter int unsigned ALU_W  = 4,
  parameter int unsigned EN_MUL = 1,
  parameter int unsigned EN_EXT = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] alu_control,
  output logic             regwrite,
  output logic             alu_src_imm,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010, ALU_SLL = 4'b0011,
    ALU_SUB  = 4'b0100, ALU_SRL = 4'b0101, ALU_MUL = 4'b0110, ALU_XOR = 4'b0111,
    ALU_SRA  = 4'b1000, ALU_SLT = 4'b1001, ALU_SLTU = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  typedef struct packed {
    logic [3:0] alu;
    logic       rw;
    logic       imm;
    logic [4:0] rd;
    logic       ill;
  } entry_t;

  occ_e   state, state_n;
  entry_t head, tail, dec;
  logic   push, pop, load_head, load_tail, move_tail;
  logic   ok, rw, imm;
  alu_op_e op;
  logic [CNT_W-1:0] cnt;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_ok;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign unused_ok = ^instr[24:15];

  always_comb begin
    ok  = 1'b1;
    op  = ALU_ADD;
    rw  = 1'b1;
    imm = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        unique case (funct7)
          7'b0000000: begin
            unique case (funct3)
              3'b000: op = ALU_ADD;
              3'b001: op = ALU_SLL;
              3'b010: begin op = ALU_SLT;  ok = (EN_EXT != 0); end
              3'b011: begin op = ALU_SLTU; ok = (EN_EXT != 0); end
              3'b100: op = ALU_XOR;
              3'b101: op = ALU_SRL;
              3'b110: op = ALU_OR;
              default: op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000) op = ALU_SUB;
            else if (funct3 == 3'b101) begin op = ALU_SRA; ok = (EN_EXT != 0); end
            else ok = 1'b0;
          end
          7'b0000001: begin
            op = ALU_MUL;
            ok = (funct3 == 3'b000) && (EN_MUL != 0);
          end
          default: ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        imm = 1'b1;
        unique case (funct3)
          3'b000: op = ALU_ADD;
          3'b001: begin op = ALU_SLL; ok = (funct7 == 7'b0000000); end
          3'b010: begin op = ALU_SLT;  ok = (EN_EXT != 0); end
          3'b011: begin op = ALU_SLTU; ok = (EN_EXT != 0); end
          3'b100: op = ALU_XOR;
          3'b101: begin
            if (funct7 == 7'b0000000) op = ALU_SRL;
            else if (funct7 == 7'b0100000) begin op = ALU_SRA; ok = (EN_EXT != 0); end
            else ok = 1'b0;
          end
          3'b110: op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      7'b0000011: begin
        imm = 1'b1;
        ok  = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      7'b0100011: begin
        imm = 1'b1;
        rw  = 1'b0;
        ok  = (funct3 inside {3'b000, 3'b001, 3'b010});
      end
      default: ok = 1'b0;
    endcase

    dec.ill = !ok;
    dec.alu = ok ? op : 4'b0000;
    dec.rw  = ok && rw;
    dec.imm = ok && imm;
    dec.rd  = (ok && rw) ? instr[11:7] : 5'd0;
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head doubles as the output register, so it keeps the last delivered entry when empty.
  always_comb begin
    state_n   = state;
    load_head = 1'b0;
    load_tail = 1'b0;
    move_tail = 1'b0;
    unique case (state)
      EMPTY: if (push) begin state_n = ONE; load_head = 1'b1; end
      ONE: begin
        if (push && pop) load_head = 1'b1;
        else if (push) begin state_n = FULL; load_tail = 1'b1; end
        else if (pop) state_n = EMPTY;
      end
      default: if (pop) begin state_n = ONE; move_tail = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (load_head) head <= dec;
      else if (move_tail) head <= tail;
      if (load_tail) tail <= dec;
      if (push && dec.ill && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

  assign alu_control = ALU_W'(head.alu);
  assign regwrite    = head.rw;
  assign alu_src_imm = head.imm;
  assign rd          = head.rd;
  assign illegal     = head.ill;
  assign illegal_cnt = cnt;

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Parametrised successor to the single-register R-type ALU control decoder.
- Decodes full 32-bit RV32 instruction words into ALU control, register-write and operand-select signals.
- Covers R-type, I-type ALU, load and store; flags illegal instructions and counts them.
- Sits between fetch and register-read/execute; valid/ready handshake on both sides through a 2-entry output buffer, so fetch is never stalled combinationally by execute.

Parameters:
- ALU_W, 4, width of alu_control; must be >= 4.
- EN_MUL, 1, 1 = decode MUL (funct7=0000001, funct3=000); 0 = such encodings illegal.
- EN_EXT, 1, 1 = decode SRA/SRAI, SLT/SLTI, SLTU/SLTIU; 0 = these encodings illegal.
- CNT_W, 8, width of illegal-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  instr is valid.
- in_ready  out  1  block can accept instr this cycle.
- instr  in  32  instruction word.
- out_valid  out  1  decoded entry at buffer head valid.
- out_ready  in  1  consumer takes head this cycle.
- alu_control  out  ALU_W  ALU operation code; upper bits above [3:0] zero.
- regwrite  out  1  destination register written.
- alu_src_imm  out  1  1 = operand B is immediate.
- rd  out  5  destination register index; 0 when regwrite=0.
- illegal  out  1  entry is an illegal/unsupported encoding.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (rst_n=0 at edge): buffer emptied; out_valid=0, alu_control=0, regwrite=0, alu_src_imm=0, rd=0, illegal=0, illegal_cnt=0. in_ready=1 on the first cycle after reset. Reset overrides any concurrent handshake; in-flight entries are discarded.
- Accept: in_valid & in_ready at an edge.
- Deliver: out_valid & out_ready at an edge pops the head.
- in_ready = (occupancy < 2). It is registered-state based only; no combinational path from out_ready.
- Latency: an instruction accepted at edge N into an empty buffer is visible on the outputs with out_valid=1 after edge N (1 cycle).
- Ordering is FIFO. Push and pop in the same cycle: occupancy unchanged, order preserved.
- Outputs are driven from the head entry and held stable while out_valid=1 & out_ready=0. When out_valid=0, outputs hold their last value.
- Decode fields: opcode = instr[6:0], funct3 = [14:12], funct7 = [31:25], rd = [11:7].
- ALU codes:
  - AND=0000, OR=0001, ADD=0010, SLL=0011, SUB=0100, SRL=0101, MUL=0110, XOR=0111.
  - SRA=1000, SLT=1001, SLTU=1010.
- Opcode 0110011 (R-type): regwrite=1, alu_src_imm=0.
  - funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: f3 000 SUB, 101 SRA.
  - funct7=0000001, f3 000: MUL.
  - Any other combination is illegal.
- Opcode 0010011 (I-type ALU): regwrite=1, alu_src_imm=1.
  - f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - f3 001: SLL only if funct7=0000000.
  - f3 101: SRL if funct7=0000000, SRA if funct7=0100000.
  - Any other combination is illegal.
- Opcode 0000011 (load): ADD, regwrite=1, alu_src_imm=1; f3 in {000,001,010,100,101}, else illegal.
- Opcode 0100011 (store): ADD, regwrite=0, alu_src_imm=1, rd=0; f3 in {000,001,010}, else illegal.
- Encodings disabled by EN_MUL=0 or EN_EXT=0 are illegal.
- Illegal entry: illegal=1, alu_control=0, regwrite=0, alu_src_imm=0, rd=0; still passes through the buffer in order.
- illegal_cnt increments by 1 at the accept edge of each illegal instruction and saturates at all-ones.

Test Plan:
- Reset then accept 0x003100B3 (add x1,x2,x3) with out_ready=1 -> next cycle out_valid=1, alu_control=0010, regwrite=1, alu_src_imm=0, rd=1, illegal=0.
- 0x403100B3 (sub) then 0x02310133 (mul x2) back-to-back -> outputs 0100/rd=1, then 0110/rd=2, in order; with EN_MUL=0 the second gives illegal=1, illegal_cnt=1.
- out_ready=0, push 3 instructions -> in_ready drops to 0 after the 2nd accept, the 3rd is held by fetch, head outputs stable; raise out_ready -> all 3 delivered in order, none lost.
- sw 0x00112023 -> alu_control=0010, regwrite=0, alu_src_imm=1, rd=0; lw 0x00012083 -> regwrite=1, rd=1.
- Stream 300 instructions of opcode 1111111 with CNT_W=8 -> illegal_cnt saturates at 255, every entry shows illegal=1, regwrite=0.
- rst_n=0 with 2 entries buffered and in_valid=1 -> after the edge out_valid=0, illegal_cnt=0, in_ready=1; the pending input is not accepted.
